// File: rtl/rstatus_commit.sv
// rstatus_commit: queues qualified overflow codes and commits them to the
// status register through the idle regfile write port. Option: RSTATUS_CNT_EN.
module rstatus_commit #(
    parameter int DEPTH      = 4,
    parameter int STATUS_REG = 30,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ovf_valid,
    input  logic [31:0]      ovf_code,
    input  logic             wb_busy,
    output logic             status_we,
    output logic [4:0]       status_addr,
    output logic [31:0]      status_data,
    output logic             pending,
    output logic             full,
    output logic             drop,
    output logic             bad_code,
    output logic [2:0]       last_cause,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [4:0] ADDR = 5'(STATUS_REG);

    logic [2:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [2:0]       last_q, last_d;
    logic             drop_q, drop_d;
    logic             bad_q, bad_d;

    logic             legal;
    logic             push;
    logic             pop;
    logic [2:0]       head;

    // Classify the incoming event and decide push / pop / drop this cycle
    always_comb begin
        legal  = ovf_valid && (ovf_code >= 32'd1) && (ovf_code <= 32'd5);
        head   = mem_q[rd_ptr_q];
        pop    = (occ_q != '0) && !wb_busy;
        push   = legal && ((occ_q != OCC_FULL) || pop);
        drop_d = legal && (occ_q == OCC_FULL) && !pop;
        bad_d  = ovf_valid && !legal;
    end

    // Next-state for pointers, occupancy and last committed cause
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        last_d   = last_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = head;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control registers; reset empties the queue and clears pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            last_q   <= '0;
            drop_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            last_q   <= last_d;
            drop_q   <= drop_d;
            bad_q    <= bad_d;
        end
    end

    // FIFO storage; only the low three code bits are kept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= ovf_code[2:0];
        end
    end

    // Commit port and status outputs
    always_comb begin
        status_we   = pop;
        status_addr = ADDR;
        status_data = pop ? {29'd0, head} : 32'd0;
        pending     = (occ_q != '0);
        full        = (occ_q == OCC_FULL);
        drop        = drop_q;
        bad_code    = bad_q;
        last_cause  = last_q;
    end

`ifdef RSTATUS_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    // Saturating per-cause commit counters
    always_comb begin
        for (int c = 0; c < 5; c++) begin
            cnt_d[c] = cnt_q[c];
            if (pop && (head == 3'(c + 1)) && (cnt_q[c] != CNT_MAX)) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 5; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 5; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Counter read mux; selects outside 1..5 read as zero
    always_comb begin
        cnt_value = '0;
        case (cnt_sel)
            3'd1:    cnt_value = cnt_q[0];
            3'd2:    cnt_value = cnt_q[1];
            3'd3:    cnt_value = cnt_q[2];
            3'd4:    cnt_value = cnt_q[3];
            3'd5:    cnt_value = cnt_q[4];
            default: cnt_value = '0;
        endcase
    end
`else
    logic unused_cnt_sel;

    // No counters in this build
    always_comb begin
        cnt_value      = '0;
        unused_cnt_sel = ^cnt_sel;
    end
`endif

endmodule

// File: tb/tb_rstatus_commit.sv
// tb_rstatus_commit: directed and random stimulus for rstatus_commit,
// checked against a queue-based reference model.
module tb_rstatus_commit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             ovf_valid;
    logic [31:0]      ovf_code;
    logic             wb_busy;
    logic             status_we;
    logic [4:0]       status_addr;
    logic [31:0]      status_data;
    logic             pending;
    logic             full;
    logic             drop;
    logic             bad_code;
    logic [2:0]       last_cause;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_value;

    int errors = 0;
    int checks = 0;

    logic [2:0] q[$];
    logic [2:0] m_last;
    int         m_cnt [1:5];

    rstatus_commit #(
        .DEPTH(DEPTH),
        .STATUS_REG(30),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clk),
        .reset(reset),
        .ovf_valid(ovf_valid),
        .ovf_code(ovf_code),
        .wb_busy(wb_busy),
        .status_we(status_we),
        .status_addr(status_addr),
        .status_data(status_data),
        .pending(pending),
        .full(full),
        .drop(drop),
        .bad_code(bad_code),
        .last_cause(last_cause),
        .cnt_sel(cnt_sel),
        .cnt_value(cnt_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 3'd0;
        for (int i = 1; i <= 5; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef RSTATUS_CNT_EN
        if (cnt_sel >= 3'd1 && cnt_sel <= 3'd5) return 32'(m_cnt[int'(cnt_sel)]);
        return 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    // One clock cycle: drive, check combinational view, clock, check pulses
    task automatic step(input logic v, input logic [31:0] c, input logic b);
        logic       e_pop;
        logic       e_legal;
        logic       e_drop;
        logic       e_bad;
        logic [2:0] hd;
        ovf_valid = v;
        ovf_code  = c;
        wb_busy   = b;
        #1;
        e_pop = (q.size() != 0) && !b;
        hd    = (q.size() != 0) ? q[0] : 3'd0;
        check("status_we", 32'(status_we), 32'(e_pop));
        check("status_data", status_data, e_pop ? 32'(hd) : 32'd0);
        check("status_addr", 32'(status_addr), 32'd30);
        check("pending", 32'(pending), 32'(q.size() != 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("last_cause", 32'(last_cause), 32'(m_last));
        check("cnt_value", 32'(cnt_value), exp_cnt());
        e_legal = v && (c >= 32'd1) && (c <= 32'd5);
        e_bad   = v && !e_legal;
        e_drop  = e_legal && (q.size() == DEPTH) && !e_pop;
        @(posedge clk);
        #1;
        if (e_pop) begin
            m_last = hd;
            void'(q.pop_front());
            if (m_cnt[int'(hd)] < CMAX) m_cnt[int'(hd)]++;
        end
        if (e_legal && !e_drop) q.push_back(c[2:0]);
        check("drop", 32'(drop), 32'(e_drop));
        check("bad_code", 32'(bad_code), 32'(e_bad));
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        ovf_valid = 1'b0;
        ovf_code  = 32'd0;
        wb_busy   = 1'b0;
        cnt_sel   = 3'd4;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_we", 32'(status_we), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_bad", 32'(bad_code), 32'd0);
        check("rst_last", 32'(last_cause), 32'd0);
        reset = 1'b0;

        // single event commits one cycle after push
        step(1'b1, 32'd3, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check("t1_last", 32'(last_cause), 32'd3);

        // fill while stalled, overflow drop, then drain in order
        step(1'b1, 32'd1, 1'b1);
        step(1'b1, 32'd2, 1'b1);
        step(1'b1, 32'd4, 1'b1);
        step(1'b1, 32'd5, 1'b1);
        check("t2_full", 32'(full), 32'd1);
        step(1'b1, 32'd3, 1'b1);
        step(1'b0, 32'd0, 1'b1);

        // push and pop together while full
        step(1'b1, 32'd2, 1'b0);
        check("t3_full", 32'(full), 32'd1);
        repeat (5) step(1'b0, 32'd0, 1'b0);
        check("t3_last", 32'(last_cause), 32'd2);

        // illegal codes
        step(1'b1, 32'd0, 1'b0);
        step(1'b1, 32'd7, 1'b0);
        step(1'b1, 32'h0000_0013, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // reset during drain
        step(1'b1, 32'd1, 1'b1);
        step(1'b1, 32'd5, 1'b1);
        step(1'b1, 32'd2, 1'b1);
        ovf_valid = 1'b0;
        wb_busy   = 1'b0;
        #1;
        check("t5_we_pre", 32'(status_we), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_we_async", 32'(status_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("t5_pending", 32'(pending), 32'd0);
        check("t5_full", 32'(full), 32'd0);
        check("t5_last", 32'(last_cause), 32'd0);

`ifdef RSTATUS_CNT_EN
        cnt_sel = 3'd4;
        repeat (5) step(1'b1, 32'd4, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        #1;
        check("t6_cnt4", 32'(cnt_value), 32'd3);
        cnt_sel = 3'd1;
        #1;
        check("t6_cnt1", 32'(cnt_value), 32'd0);
        cnt_sel = 3'd0;
        #1;
        check("t6_cnt0", 32'(cnt_value), 32'd0);
        @(negedge clk);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] c;
            c = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) c = c | 32'h0001_0000;
            cnt_sel = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), c,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end
        repeat (6) step(1'b0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
